splitting_4kb_ctrl: RTL and testbench
=====================================

Name: splitting_4kb_ctrl

Overview:
Sequencer for one AXI address channel (AW or AR) that splits any burst crossing a 4KB boundary into two legal sub-bursts. It sits between the slave-side address port of the interconnect and the downstream master port. It holds the accepted request, computes the crossing and split fields internally, and issues one or two address beats. It also pushes a per-request split record into an internal FIFO, which the response-merge logic pops.

Parameters:
ADDR_WIDTH, 32, address width
ID_WIDTH, 4, transaction ID width
LEN_WIDTH, 8, AxLEN width
SIZE_WIDTH, 3, AxSIZE width
INFO_DEPTH, 4, split-info FIFO depth (power of 2, >=2)

Ports:
ACLK_i  in  1  clock
ARESET_i  in  1  synchronous reset, active-high
AxID_i  in  ID_WIDTH  request ID
AxADDR_i  in  ADDR_WIDTH  request start address (size-aligned)
AxLEN_i  in  LEN_WIDTH  beats-1
AxSIZE_i  in  SIZE_WIDTH  log2 bytes/beat
AxVALID_i  in  1  request valid
AxREADY_o  out  1  request accepted
AxID_o  out  ID_WIDTH  downstream ID
AxADDR_o  out  ADDR_WIDTH  downstream address
AxLEN_o  out  LEN_WIDTH  downstream len
AxSIZE_o  out  SIZE_WIDTH  downstream size
AxVALID_o  out  1  downstream valid
AxREADY_i  in  1  downstream ready
info_id_o  out  ID_WIDTH  FIFO head: ID
info_split_o  out  1  FIFO head: 1 = request was split in two
info_valid_o  out  1  FIFO not empty
info_ready_i  in  1  pop FIFO head

Behaviour:
- Clock and reset: single clock ACLK_i. ARESET_i is synchronous and active-high.
- Reset: state=IDLE; AxVALID_o=0; AxREADY_o=0 during reset, then follows its equation; FIFO emptied (info_valid_o=0). Data outputs are 0 at reset. Reset mid-burst abandons the pending sub-burst and no FIFO entry survives.
- States: IDLE, SEND_1, SEND_2.
- AxREADY_o = (state==IDLE) & ~fifo_full. It is combinational from registered state and count only; it does not depend on info_ready_i.
- Accept (AxVALID_i & AxREADY_o):
  - Register ID, ADDR, LEN, SIZE and crossing flag.
  - Push {ID, crossing} into the FIFO in the same cycle.
  - Next state SEND_1.
- Crossing arithmetic:
  - bytes = (LEN+1)<<SIZE, widened so it cannot overflow.
  - end = {1'b0, ADDR[11:0]} + bytes (13 bits).
  - crossing = end[12] & (end[11:0]!=0). Ending exactly on the boundary is not a crossing.
- SEND_1: AxVALID_o=1.
  - Not crossing: AxADDR_o=ADDR, AxLEN_o=LEN.
  - Crossing: AxADDR_o=ADDR, AxLEN_o=((4096-ADDR[11:0])>>SIZE)-1.
  - On AxREADY_i: go to SEND_2 if crossing, else IDLE.
- SEND_2: AxVALID_o=1, AxADDR_o={ADDR[AW-1:12]+1, 12'h000}, AxLEN_o=(end[11:0]>>SIZE)-1. On AxREADY_i, go to IDLE.
- All sub-bursts keep AxID_o=ID and AxSIZE_o=SIZE.
- Outputs are registered or derived from registered state only. They stay stable while AxVALID_o=1 & AxREADY_i=0 (AXI rule). AxVALID_o never drops before the handshake.
- Latency: first downstream valid appears the cycle after accept. A new accept is possible the cycle after the last handshake. Peak throughput is 1 request per 2 cycles unsplit, 1 per 3 cycles split.
- FIFO: INFO_DEPTH entries with wrap-around pointers.
  - Pop = info_valid_o & info_ready_i.
  - Simultaneous push and pop is allowed when not full and not empty; the count is unchanged.
  - Push while full cannot occur because AxREADY_o is low.
  - Pop while empty is ignored.
- AxADDR_i must be aligned to AxSIZE_i; unaligned requests are out of scope. AxLEN_i+1 is always at most 256.

Test Plan:
- Unsplit: ADDR=0x0000_0F80, LEN=15, SIZE=3 (end exactly 0x1000) -> one beat ADDR=0x0F80 LEN=15; info_split=0.
- Split: ADDR=0x0000_0FC0, LEN=15, SIZE=3 -> beat1 ADDR=0x0FC0 LEN=7, beat2 ADDR=0x1000 LEN=7; info_split=1; AxREADY_o low until beat2 handshake.
- Split, high address: ID=5, ADDR=0x1234_5FF0, LEN=7, SIZE=2 -> beat1 0x1234_5FF0 LEN=3, beat2 0x1234_6000 LEN=3; both carry ID=5.
- Backpressure: hold AxREADY_i=0 for 3 cycles during SEND_1 -> AxVALID_o and all fields constant; beat2 appears only after handshake.
- FIFO full: 4 unsplit requests accepted with info_ready_i=0 -> AxREADY_o=0 with AxVALID_i held. Pop one -> AxREADY_o=1 next cycle. Heads return in order with correct IDs.
- Reset in SEND_2: assert ARESET_i for 1 cycle -> AxVALID_o=0, info_valid_o=0, state IDLE. Next request is handled normally.

Source files
------------

// File: rtl/splitting_4kb_ctrl.sv
// AXI address-channel sequencer: splits any burst that crosses a 4KB page into two legal
// sub-bursts and records, per accepted request, whether it was split.
module splitting_4kb_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int SIZE_WIDTH = 3,
    parameter int INFO_DEPTH = 4
) (
    input  logic                  ACLK_i,
    input  logic                  ARESET_i,
    input  logic [ID_WIDTH-1:0]   AxID_i,
    input  logic [ADDR_WIDTH-1:0] AxADDR_i,
    input  logic [LEN_WIDTH-1:0]  AxLEN_i,
    input  logic [SIZE_WIDTH-1:0] AxSIZE_i,
    input  logic                  AxVALID_i,
    output logic                  AxREADY_o,
    output logic [ID_WIDTH-1:0]   AxID_o,
    output logic [ADDR_WIDTH-1:0] AxADDR_o,
    output logic [LEN_WIDTH-1:0]  AxLEN_o,
    output logic [SIZE_WIDTH-1:0] AxSIZE_o,
    output logic                  AxVALID_o,
    input  logic                  AxREADY_i,
    output logic [ID_WIDTH-1:0]   info_id_o,
    output logic                  info_split_o,
    output logic                  info_valid_o,
    input  logic                  info_ready_i
);

    localparam int PTR_W   = $clog2(INFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BYTES_W = (LEN_WIDTH + (1 << SIZE_WIDTH) > 13) ? LEN_WIDTH + (1 << SIZE_WIDTH) : 13;

    typedef enum logic [1:0] {IDLE, SEND_1, SEND_2} state_t;

    state_t state, next_state;

    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [SIZE_WIDTH-1:0] size_q;
    logic                  cross_q;

    logic [ID_WIDTH-1:0] fifo_id    [INFO_DEPTH];
    logic                fifo_split [INFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                fifo_full;
    logic                push, pop;
    logic                accept;

    logic [12:0] end_in, end_q;
    logic        cross_in;
    logic [12:0] first_beats, second_beats;
    logic [LEN_WIDTH-1:0]  first_len, second_len;
    logic [ADDR_WIDTH-1:0] second_addr;

    // Offset of the first byte past the burst, relative to the 4KB page of its start.
    function automatic logic [12:0] end_offset(input logic [11:0] a12,
                                               input logic [LEN_WIDTH-1:0] l,
                                               input logic [SIZE_WIDTH-1:0] s);
        logic [BYTES_W-1:0] bytes;
        bytes = (BYTES_W'(l) + BYTES_W'(1)) << s;
        return 13'(BYTES_W'(a12) + bytes);
    endfunction

    assign end_in   = end_offset(AxADDR_i[11:0], AxLEN_i, AxSIZE_i);
    assign cross_in = end_in[12] & (end_in[11:0] != 12'h000);
    assign end_q    = end_offset(addr_q[11:0], len_q, size_q);

    assign first_beats  = (13'h1000 - {1'b0, addr_q[11:0]}) >> size_q;
    assign second_beats = (end_q & 13'h0FFF) >> size_q;
    assign first_len    = LEN_WIDTH'(first_beats - 13'd1);
    assign second_len   = LEN_WIDTH'(second_beats - 13'd1);
    assign second_addr  = {addr_q[ADDR_WIDTH-1:12] + (ADDR_WIDTH-12)'(1), 12'h000};

    assign fifo_full = (count == CNT_W'(INFO_DEPTH));
    assign AxREADY_o = (state == IDLE) & ~fifo_full & ~ARESET_i;
    assign accept    = AxVALID_i & AxREADY_o;
    assign push      = accept;
    assign pop       = info_valid_o & info_ready_i;

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        AxVALID_o  = 1'b0;
        AxADDR_o   = addr_q;
        AxLEN_o    = len_q;
        case (state)
            IDLE: begin
                if (accept) next_state = SEND_1;
            end
            SEND_1: begin
                AxVALID_o = 1'b1;
                if (cross_q) AxLEN_o = first_len;
                if (AxREADY_i) next_state = cross_q ? SEND_2 : IDLE;
            end
            SEND_2: begin
                AxVALID_o = 1'b1;
                AxADDR_o  = second_addr;
                AxLEN_o   = second_len;
                if (AxREADY_i) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign AxID_o   = id_q;
    assign AxSIZE_o = size_q;

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            cross_q <= 1'b0;
        end else if (accept) begin
            id_q    <= AxID_i;
            addr_q  <= AxADDR_i;
            len_q   <= AxLEN_i;
            size_q  <= AxSIZE_i;
            cross_q <= cross_in;
        end
    end

    // Split-info FIFO; pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < INFO_DEPTH; i++) begin
                fifo_id[i]    <= '0;
                fifo_split[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_id[wr_ptr]    <= AxID_i;
                fifo_split[wr_ptr] <= cross_in;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign info_valid_o = (count != '0);
    assign info_id_o    = fifo_id[rd_ptr];
    assign info_split_o = fifo_split[rd_ptr];

endmodule

// File: tb/tb_splitting_4kb_ctrl.sv
// Bench for splitting_4kb_ctrl: table of requests with hand-computed sub-bursts, scoreboard
// queues for downstream beats and split-info records, plus multi-cycle corner sequences.
module tb_splitting_4kb_ctrl;

    logic        ACLK_i = 1'b0;
    logic        ARESET_i;
    logic [3:0]  AxID_i;
    logic [31:0] AxADDR_i;
    logic [7:0]  AxLEN_i;
    logic [2:0]  AxSIZE_i;
    logic        AxVALID_i;
    logic        AxREADY_o;
    logic [3:0]  AxID_o;
    logic [31:0] AxADDR_o;
    logic [7:0]  AxLEN_o;
    logic [2:0]  AxSIZE_o;
    logic        AxVALID_o;
    logic        AxREADY_i;
    logic [3:0]  info_id_o;
    logic        info_split_o;
    logic        info_valid_o;
    logic        info_ready_i;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic        split;
        logic [7:0]  len1;
        logic [31:0] addr2;
        logic [7:0]  len2;
    } vec_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } beat_t;

    typedef struct {
        logic [3:0] id;
        logic       split;
    } info_t;

    beat_t exp_beats[$];
    info_t exp_info[$];
    vec_t  vecs[10];
    int    tests = 0;
    int    fails = 0;

    splitting_4kb_ctrl dut (
        .ACLK_i(ACLK_i), .ARESET_i(ARESET_i),
        .AxID_i(AxID_i), .AxADDR_i(AxADDR_i), .AxLEN_i(AxLEN_i), .AxSIZE_i(AxSIZE_i),
        .AxVALID_i(AxVALID_i), .AxREADY_o(AxREADY_o),
        .AxID_o(AxID_o), .AxADDR_o(AxADDR_o), .AxLEN_o(AxLEN_o), .AxSIZE_o(AxSIZE_o),
        .AxVALID_o(AxVALID_o), .AxREADY_i(AxREADY_i),
        .info_id_o(info_id_o), .info_split_o(info_split_o),
        .info_valid_o(info_valid_o), .info_ready_i(info_ready_i)
    );

    always #5 ACLK_i = ~ACLK_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushExpect(input vec_t v);
        exp_beats.push_back('{v.id, v.addr, v.len1, v.size});
        if (v.split) exp_beats.push_back('{v.id, v.addr2, v.len2, v.size});
        exp_info.push_back('{v.id, v.split});
    endtask

    task automatic applyStimulus(input vec_t v);
        int waited = 0;
        @(posedge ACLK_i); #1;
        AxID_i    = v.id;
        AxADDR_i  = v.addr;
        AxLEN_i   = v.len;
        AxSIZE_i  = v.size;
        AxVALID_i = 1'b1;
        forever begin
            @(negedge ACLK_i);
            if (AxREADY_o) break;
            waited++;
            if (waited > 100) begin
                checkOutput("accept_timeout", 32'd0, 32'd1);
                AxVALID_i = 1'b0;
                return;
            end
        end
        pushExpect(v);
        @(posedge ACLK_i); #1;
        AxVALID_i = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((exp_beats.size() != 0 || exp_info.size() != 0) && n < 300) begin
            @(negedge ACLK_i);
            n++;
        end
        checkOutput(name, 32'(exp_beats.size() + exp_info.size()), 32'd0);
    endtask

    // Scoreboard: compare every downstream handshake and every info pop against the queues.
    always @(negedge ACLK_i) begin
        beat_t b;
        info_t r;
        if (!ARESET_i) begin
            if (AxVALID_o && AxREADY_i) begin
                if (exp_beats.size() == 0) checkOutput("unexpected_beat", 32'd1, 32'd0);
                else begin
                    b = exp_beats.pop_front();
                    checkOutput("beat_id",   32'(AxID_o),   32'(b.id));
                    checkOutput("beat_addr", AxADDR_o,      b.addr);
                    checkOutput("beat_len",  32'(AxLEN_o),  32'(b.len));
                    checkOutput("beat_size", 32'(AxSIZE_o), 32'(b.size));
                end
            end
            if (info_valid_o && info_ready_i) begin
                if (exp_info.size() == 0) checkOutput("unexpected_info", 32'd1, 32'd0);
                else begin
                    r = exp_info.pop_front();
                    checkOutput("info_id",    32'(info_id_o),    32'(r.id));
                    checkOutput("info_split", 32'(info_split_o), 32'(r.split));
                end
            end
        end
    end

    initial begin
        vec_t v5;
        vecs[0] = '{4'd1,  32'h0000_0F80, 8'd15,  3'd3, 1'b0, 8'd15,  32'h0,         8'd0};
        vecs[1] = '{4'd2,  32'h0000_0FC0, 8'd15,  3'd3, 1'b1, 8'd7,   32'h0000_1000, 8'd7};
        vecs[2] = '{4'd5,  32'h1234_5FF0, 8'd7,   3'd2, 1'b1, 8'd3,   32'h1234_6000, 8'd3};
        vecs[3] = '{4'd3,  32'h0000_0100, 8'd3,   3'd2, 1'b0, 8'd3,   32'h0,         8'd0};
        vecs[4] = '{4'd7,  32'hABCD_0FFC, 8'd0,   3'd2, 1'b0, 8'd0,   32'h0,         8'd0};
        vecs[5] = '{4'd9,  32'h0000_0FF8, 8'd1,   3'd3, 1'b1, 8'd0,   32'h0000_1000, 8'd0};
        vecs[6] = '{4'd15, 32'hFFFF_FF00, 8'd255, 3'd0, 1'b0, 8'd255, 32'h0,         8'd0};
        vecs[7] = '{4'd4,  32'h7000_0E00, 8'd127, 3'd4, 1'b1, 8'd31,  32'h7000_1000, 8'd95};
        vecs[8] = '{4'd6,  32'hFFFF_F800, 8'd255, 3'd3, 1'b0, 8'd255, 32'h0,         8'd0};
        vecs[9] = '{4'd11, 32'hFFFF_FFF0, 8'd3,   3'd3, 1'b1, 8'd1,   32'h0000_0000, 8'd1};

        ARESET_i = 1'b1;
        AxID_i = '0; AxADDR_i = '0; AxLEN_i = '0; AxSIZE_i = '0; AxVALID_i = 1'b0;
        AxREADY_i = 1'b1;
        info_ready_i = 1'b1;

        repeat (2) @(posedge ACLK_i);
        @(negedge ACLK_i);
        checkOutput("ready_in_reset", 32'(AxREADY_o), 32'd0);
        @(posedge ACLK_i); #1;
        ARESET_i = 1'b0;
        @(negedge ACLK_i);
        checkOutput("rst_valid",      32'(AxVALID_o),    32'd0);
        checkOutput("rst_info_valid", 32'(info_valid_o), 32'd0);
        checkOutput("rst_ready",      32'(AxREADY_o),    32'd1);
        checkOutput("rst_addr",       AxADDR_o,          32'd0);
        checkOutput("rst_len",        32'(AxLEN_o),      32'd0);
        checkOutput("rst_id",         32'(AxID_o),       32'd0);

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);
        waitDrain("table_drain");

        // Split request keeps the upstream port closed until the second beat completes.
        applyStimulus(vecs[1]);
        @(negedge ACLK_i);
        checkOutput("split_ready_s1", 32'(AxREADY_o), 32'd0);
        @(negedge ACLK_i);
        checkOutput("split_ready_s2", 32'(AxREADY_o), 32'd0);
        @(negedge ACLK_i);
        checkOutput("split_ready_idle", 32'(AxREADY_o), 32'd1);
        waitDrain("split_drain");

        // Backpressure during the first sub-burst.
        @(posedge ACLK_i); #1;
        AxREADY_i = 1'b0;
        applyStimulus(vecs[2]);
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK_i);
            checkOutput("bp_valid", 32'(AxVALID_o), 32'd1);
            checkOutput("bp_addr",  AxADDR_o,       32'h1234_5FF0);
            checkOutput("bp_len",   32'(AxLEN_o),   32'd3);
            checkOutput("bp_id",    32'(AxID_o),    32'd5);
            checkOutput("bp_size",  32'(AxSIZE_o),  32'd2);
        end
        @(posedge ACLK_i); #1;
        AxREADY_i = 1'b1;
        waitDrain("bp_drain");

        // Fill the info FIFO, then show that one pop reopens the request port.
        @(posedge ACLK_i); #1;
        info_ready_i = 1'b0;
        for (int k = 0; k < 4; k++)
            applyStimulus('{4'(8 + k), 32'(k * 256), 8'd0, 3'd2, 1'b0, 8'd0, 32'h0, 8'd0});
        v5 = '{4'd12, 32'h0000_0400, 8'd0, 3'd2, 1'b0, 8'd0, 32'h0, 8'd0};
        AxID_i = v5.id; AxADDR_i = v5.addr; AxLEN_i = v5.len; AxSIZE_i = v5.size;
        AxVALID_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK_i);
            checkOutput("full_ready", 32'(AxREADY_o), 32'd0);
        end
        checkOutput("full_head_id", 32'(info_id_o), 32'd8);
        checkOutput("full_info_valid", 32'(info_valid_o), 32'd1);
        @(posedge ACLK_i); #1;
        info_ready_i = 1'b1;
        @(posedge ACLK_i); #1;
        info_ready_i = 1'b0;
        @(negedge ACLK_i);
        checkOutput("pop_reopens_ready", 32'(AxREADY_o), 32'd1);
        pushExpect(v5);
        @(posedge ACLK_i); #1;
        AxVALID_i = 1'b0;
        info_ready_i = 1'b1;
        waitDrain("full_drain");

        // Reset while the second sub-burst is pending.
        @(posedge ACLK_i); #1;
        AxREADY_i = 1'b0;
        info_ready_i = 1'b0;
        applyStimulus(vecs[2]);
        AxREADY_i = 1'b1;
        @(posedge ACLK_i); #1;
        AxREADY_i = 1'b0;
        ARESET_i = 1'b1;
        checkOutput("pre_reset_beats_left", 32'(exp_beats.size()), 32'd1);
        exp_beats.delete();
        exp_info.delete();
        @(posedge ACLK_i); #1;
        ARESET_i = 1'b0;
        @(negedge ACLK_i);
        checkOutput("mid_rst_valid",      32'(AxVALID_o),    32'd0);
        checkOutput("mid_rst_info_valid", 32'(info_valid_o), 32'd0);
        checkOutput("mid_rst_ready",      32'(AxREADY_o),    32'd1);
        AxREADY_i = 1'b1;
        info_ready_i = 1'b1;
        applyStimulus(vecs[7]);
        waitDrain("post_reset_drain");

        repeat (3) @(posedge ACLK_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
